// File: rtl/mips_cpu_pkg.sv
// ============================================================================
// Module      : mips_cpu_pkg
// Description : Shared types and constants for the MIPS CPU memory arbiter.
//               arb_state_t  - arbiter grant state
//               grant_side_t - most recent grant winner (fetch / data)
//               BE_ALL       - all-lanes byteenable for the 32-bit CPU bus
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_cpu_pkg;

    localparam int CPU_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } grant_side_t;

    localparam logic [CPU_DATA_W/8-1:0] BE_ALL = '1;

endpackage

`default_nettype wire

// File: rtl/mips_cpu_mem_arbiter_if.sv
// ============================================================================
// Module      : mips_cpu_mem_arbiter_if
// Description : Signal bundle around the fetch/data memory arbiter.
//               Fetch requester : i_read, i_address, i_waitrequest, i_readdata
//               Data requester  : d_read, d_write, d_address, d_writedata,
//                                 d_byteenable, d_waitrequest, d_readdata
//               Memory master   : address, read, write, writedata,
//                                 byteenable, readdata, waitrequest
//               Status          : protocol_err
//               modport slave  - the arbiter's view
//               modport master - the requesters' and memory's view
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_cpu_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic              i_waitrequest;
    logic [DATA_W-1:0] i_readdata;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_writedata;
    logic [BE_W-1:0]   d_byteenable;
    logic              d_waitrequest;
    logic [DATA_W-1:0] d_readdata;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    logic              protocol_err;

    modport slave (
        input  i_read, i_address,
        input  d_read, d_write, d_address, d_writedata, d_byteenable,
        input  readdata, waitrequest,
        output i_waitrequest, i_readdata,
        output d_waitrequest, d_readdata,
        output address, read, write, writedata, byteenable,
        output protocol_err
    );

    modport master (
        output i_read, i_address,
        output d_read, d_write, d_address, d_writedata, d_byteenable,
        output readdata, waitrequest,
        input  i_waitrequest, i_readdata,
        input  d_waitrequest, d_readdata,
        input  address, read, write, writedata, byteenable,
        input  protocol_err
    );

endinterface

`default_nettype wire

// File: rtl/mips_cpu_mem_arbiter.sv
// ============================================================================
// Module      : mips_cpu_mem_arbiter
// Description : Shares the CPU's single Avalon-MM memory master between the
//               instruction-fetch and data requesters. One grant at a time,
//               held until the memory drops waitrequest; ties are resolved
//               round-robin; protocol violations set a sticky error flag.
//   clk    - clock
//   reset  - synchronous, active-high reset
//   bus    - requester, memory and status signals (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_cpu_mem_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic               clk,
    input  wire logic               reset,
    mips_cpu_mem_arbiter_if.slave   bus
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [BE_W-1:0] C_BE_ALL =
        (BE_W == $bits(BE_ALL)) ? BE_W'(BE_ALL) : {BE_W{1'b1}};

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    grant_side_t r_last_grant;
    logic        r_protocol_err;

    logic              w_d_req;
    logic              w_err_event;
    logic [ADDR_W-1:0] w_address;
    logic              w_read;
    logic              w_write;
    logic [DATA_W-1:0] w_writedata;
    logic [BE_W-1:0]   w_byteenable;
    logic              w_i_waitrequest;
    logic              w_d_waitrequest;

    assign w_d_req = bus.d_read | bus.d_write;

    // Bus drive: purely a function of the current grant and live inputs.
    always_comb begin
        w_address       = '0;
        w_read          = 1'b0;
        w_write         = 1'b0;
        w_writedata     = '0;
        w_byteenable    = '0;
        w_i_waitrequest = 1'b1;
        w_d_waitrequest = 1'b1;
        case (r_state)
            ARB_GRANT_I: begin
                w_address       = bus.i_address;
                w_read          = 1'b1;
                w_byteenable    = C_BE_ALL;
                w_i_waitrequest = bus.waitrequest;
            end
            ARB_GRANT_D: begin
                w_address       = bus.d_address;
                // Simultaneous read+write is resolved as a write.
                w_read          = bus.d_read & ~bus.d_write;
                w_write         = bus.d_write;
                w_writedata     = bus.d_writedata;
                w_byteenable    = bus.d_byteenable;
                w_d_waitrequest = bus.waitrequest;
            end
            default: ;
        endcase
    end

    // Next grant. A transfer ends on completion or when the granted side
    // abandons its request mid-stall.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (bus.i_read && w_d_req)
                    w_next_state = (r_last_grant == LAST_D) ? ARB_GRANT_I : ARB_GRANT_D;
                else if (bus.i_read)
                    w_next_state = ARB_GRANT_I;
                else if (w_d_req)
                    w_next_state = ARB_GRANT_D;
            end
            ARB_GRANT_I: begin
                if (!bus.waitrequest || !bus.i_read)
                    w_next_state = ARB_IDLE;
            end
            ARB_GRANT_D: begin
                if (!bus.waitrequest || !w_d_req)
                    w_next_state = ARB_IDLE;
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_err_event = 1'b0;
        if (bus.d_read && bus.d_write && (r_state != ARB_GRANT_I))
            w_err_event = 1'b1;
        if ((r_state == ARB_GRANT_I) && bus.waitrequest && !bus.i_read)
            w_err_event = 1'b1;
        if ((r_state == ARB_GRANT_D) && bus.waitrequest && !w_d_req)
            w_err_event = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ARB_IDLE;
            r_last_grant   <= LAST_D;   // first tie after reset goes to fetch
            r_protocol_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ARB_IDLE) && (w_next_state != ARB_IDLE))
                r_last_grant <= (w_next_state == ARB_GRANT_I) ? LAST_I : LAST_D;
            if (w_err_event)
                r_protocol_err <= 1'b1;
        end
    end

    assign bus.address       = w_address;
    assign bus.read          = w_read;
    assign bus.write         = w_write;
    assign bus.writedata     = w_writedata;
    assign bus.byteenable    = w_byteenable;
    assign bus.i_waitrequest = w_i_waitrequest;
    assign bus.d_waitrequest = w_d_waitrequest;
    assign bus.i_readdata    = bus.readdata;
    assign bus.d_readdata    = bus.readdata;
    assign bus.protocol_err  = r_protocol_err;

endmodule

`default_nettype wire

// File: doc/mips_cpu_mem_arbiter.md
# mips_cpu_mem_arbiter

Two-port arbiter that shares the CPU's single Avalon-MM memory master between the instruction-fetch requester and the data (load/store) requester. It sits between the multicycle control/datapath and the external memory bus. It grants one requester at a time, holds the grant until the bus completes the transfer (waitrequest low), and returns per-requester waitrequest and readdata. Contention is resolved round-robin, and Avalon protocol violations raise a sticky error flag.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byteenable width is DATA_W/8
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_read  in  1  instruction-fetch read request
- i_address  in  ADDR_W  fetch address
- i_waitrequest  out  1  low only in the fetch completion cycle
- i_readdata  out  DATA_W  fetch data, valid when i_waitrequest=0
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_address  in  ADDR_W  data address
- d_writedata  in  DATA_W  store data
- d_byteenable  in  DATA_W/8  store/load byte lanes
- d_waitrequest  out  1  low only in the data completion cycle
- d_readdata  out  DATA_W  load data, valid when d_waitrequest=0
- address  out  ADDR_W  memory address
- read  out  1  memory read strobe
- write  out  1  memory write strobe
- writedata  out  DATA_W  memory write data
- byteenable  out  DATA_W/8  memory byte lanes
- readdata  in  DATA_W  memory read data
- waitrequest  in  1  memory stall
- protocol_err  out  1  sticky protocol-violation flag

## Operation
- States: IDLE, GRANT_I, GRANT_D. A register last_grant (I/D) records the most recent winner.
- **IDLE**
  - Drives read=0, write=0, address=0, writedata=0, byteenable=0.
  - Holds both i_waitrequest and d_waitrequest at 1.
  - Next state: GRANT_I if only i_read is set; GRANT_D if only d_req (d_read|d_write) is set.
  - If both are set, the side not equal to last_grant wins. last_grant updates on entry to a GRANT state.
- **GRANT_I**
  - Drives address=i_address, read=1, write=0, byteenable=all-ones, writedata=0.
  - i_waitrequest = waitrequest; d_waitrequest stays 1.
  - On waitrequest=0: completion; next state is IDLE.
- **GRANT_D**
  - Drives address=d_address, read=d_read&~d_write, write=d_write, writedata=d_writedata, byteenable=d_byteenable.
  - d_waitrequest = waitrequest; i_waitrequest stays 1.
  - On waitrequest=0: completion; next state is IDLE.
- **Readdata:** i_readdata and d_readdata are direct passthroughs of readdata. They are meaningful only in the respective completion cycle.
- **Protocol errors** set protocol_err (cleared only by reset) in these cases:
  - d_read and d_write both set while in IDLE or GRANT_D. This is treated as a write.
  - The granted requester deasserts its request while waitrequest=1 in a GRANT state. The arbiter drops the grant, returns to IDLE next cycle, and the bus strobes go low that cycle.
- **Reset**, including mid-transfer: state=IDLE, last_grant=D (so the first tie goes to I), protocol_err=0. All bus outputs are 0 and both requester waitrequests are 1.

## Timing
- Bus outputs and requester waitrequests are combinational from the registered state plus the inputs. State, last_grant and protocol_err are registered.
- Minimum transfer is 2 cycles:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: GRANT state; with waitrequest=0 this is the completion cycle.
  - Cycle 2: IDLE.
- Each extra cycle of memory waitrequest adds one cycle.
- Back-to-back requests from the same requester are separated by one IDLE cycle.
- Under continuous contention, grants alternate I, D, I, D.
- A requester must hold its request and operands stable until it sees its waitrequest low. The arbiter does not latch requester operands.
- A request arriving while the other side is granted waits. There is no preemption.

## Structure
- Shared package mips_cpu_pkg holds:
  - typedef enum logic[1:0] arb_state_t {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D}
  - constant BE_ALL (all-ones byteenable)
- No sub-module is needed. The round-robin choice is a single inline comparison.

## Test plan
- **Fetch only:** i_read=1, i_address=0xBFC00000, waitrequest=0, readdata=0x24020005 -> read=1 and address=0xBFC00000 in cycle 1; i_waitrequest=0 and i_readdata=0x24020005 in cycle 1; IDLE in cycle 2.
- **Stalled store:** d_write=1, d_address=0x1004, d_writedata=0xDEADBEEF, d_byteenable=0b0011, waitrequest=1 for 3 cycles -> write=1 and byteenable=0b0011 held for 4 cycles; d_waitrequest=0 only in the 4th.
- **Contention after reset:** i_read and d_read both held -> grants go I, D, I across three transfers; the waiting side's waitrequest stays 1 throughout.
- **Request dropped mid-grant:** GRANT_D with waitrequest=1, d_read drops -> next cycle IDLE with read=0; protocol_err=1 and it stays 1 until reset.
- **Simultaneous read and write:** d_read=d_write=1 -> write=1, read=0, protocol_err=1.
- **Reset mid-transfer:** reset asserted in GRANT_I with waitrequest=1 -> next cycle read=0, address=0, i_waitrequest=1, protocol_err=0, and the next tie is granted to I.
